// File: rtl/btn_conditioner.sv
// Button conditioner: synchronizes, debounces and edge-detects raw active-low push-buttons
// into one-cycle active-low step pulses, with optional auto-repeat and inc/dec conflict veto.
module btn_conditioner #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned REPEAT_DLY   = 0,
    parameter int unsigned REPEAT_PER   = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] pulse_n,
    output logic [N_BTN-1:0] held,
    output logic             conflict
);

    localparam int unsigned MAX_A = (DEBOUNCE_CYC > REPEAT_DLY) ? DEBOUNCE_CYC : REPEAT_DLY;
    localparam int unsigned MAX_C = (MAX_A > REPEAT_PER) ? MAX_A : REPEAT_PER;
    localparam int unsigned CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] DLY_C  = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] PER_C  = CW'(REPEAT_PER - 1);
    localparam bit            RPT_EN = (REPEAT_DLY > 0);

    typedef enum logic [1:0] {StIdle, StDebP, StHold} state_t;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] fire, blocked;
    logic             conflict_q;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        localparam int unsigned PARTNER = i ^ 2;

        state_t        state_q;
        logic [CW-1:0] cnt_q, rpt_q;
        logic          phase_q, pulse_q, held_q;
        logic          s, fire_c;

        assign s = sync2_q[i];

        // phase_q selects between the initial repeat delay and the repeat period
        always_comb begin
            fire_c = 1'b0;
            case (state_q)
                StDebP:  fire_c = !s && (cnt_q == DEB_C);
                StHold:  fire_c = RPT_EN && (phase_q ? (rpt_q == PER_C) : (rpt_q == DLY_C));
                default: fire_c = 1'b0;
            endcase
        end

        assign fire[i] = fire_c;

        if (PARTNER < N_BTN) begin : g_pair
            assign blocked[i] = fire[PARTNER];
        end else begin : g_solo
            assign blocked[i] = 1'b0;
        end

        // In HOLD, cnt_q doubles as the consecutive-release counter
        always_ff @(posedge clkin or negedge reset) begin
            if (!reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                rpt_q   <= '0;
                phase_q <= 1'b0;
                pulse_q <= 1'b1;
                held_q  <= 1'b0;
            end else begin
                pulse_q <= !(fire_c && !blocked[i]);
                case (state_q)
                    StIdle: begin
                        held_q <= 1'b0;
                        if (!s) begin
                            state_q <= StDebP;
                            cnt_q   <= CW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StDebP: begin
                        if (s) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_C) begin
                            state_q <= StHold;
                            held_q  <= 1'b1;
                            cnt_q   <= '0;
                            rpt_q   <= '0;
                            phase_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StHold: begin
                        if (!s) begin
                            cnt_q <= '0;
                        end else if (cnt_q == DEB_C - 1'b1) begin
                            state_q <= StIdle;
                            held_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (RPT_EN) begin
                            if (fire_c) begin
                                rpt_q   <= '0;
                                phase_q <= 1'b1;
                            end else begin
                                rpt_q <= rpt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign pulse_n[i] = pulse_q;
        assign held[i]    = held_q;
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= |(fire & blocked);
        end
    end

    assign conflict = conflict_q;

    // A repeat period of 1 would hold pulse_n low continuously
    always_ff @(posedge clkin) begin
        if (reset && RPT_EN) begin
            assert (REPEAT_PER >= 2);
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: expected pulse/conflict times are queued when a
// button is driven and popped by a negedge monitor whenever the DUT asserts an output.
`timescale 1ns/1ps
module tb_btn_conditioner;

    localparam int unsigned N   = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned DLY = 20;
    localparam int unsigned PER = 8;

    logic         clkin = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] pulse_n;
    logic [N-1:0] held;
    logic         conflict;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_err  = 0;
    int exp_q[N][$];
    int cfl_q[$];
    bit mon_en = 1'b0;

    btn_conditioner #(
        .N_BTN       (N),
        .DEBOUNCE_CYC(DEB),
        .REPEAT_DLY  (DLY),
        .REPEAT_PER  (PER)
    ) dut (
        .clkin   (clkin),
        .reset   (reset),
        .btn_n   (btn_n),
        .pulse_n (pulse_n),
        .held    (held),
        .conflict(conflict)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clkin);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Scoreboard side: every low pulse / conflict must match the head of its queue
    always @(negedge clkin) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                if (!pulse_n[i]) begin
                    if (exp_q[i].size() == 0)
                        check($sformatf("unexpected pulse ch%0d", i), cyc, -1);
                    else
                        check($sformatf("pulse time ch%0d", i), cyc, exp_q[i].pop_front());
                end
            end
            if (conflict) begin
                if (cfl_q.size() == 0) check("unexpected conflict", cyc, -1);
                else                   check("conflict time", cyc, cfl_q.pop_front());
            end
        end
    end

    initial begin
        int c, c0;
        int pat[6] = '{1, 1, 2, 2, 1, 2};

        #1 reset = 1'b0;
        #20;
        check("reset pulse_n", int'(pulse_n), 15);
        check("reset held", int'(held), 0);
        check("reset conflict", int'(conflict), 0);
        @(negedge clkin);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(4);

        // Clean press with auto-repeat
        c = cyc;
        btn_n[1] = 1'b0;
        exp_q[1].push_back(c + 7);
        exp_q[1].push_back(c + 27);
        exp_q[1].push_back(c + 35);
        wait_to(c + 6);
        check("t1 held before pulse", int'(held[1]), 0);
        wait_to(c + 7);
        check("t1 held at pulse", int'(held[1]), 1);
        wait_to(c + 36);
        btn_n[1] = 1'b1;
        wait_to(c + 41);
        check("t1 held before release", int'(held[1]), 1);
        wait_to(c + 42);
        check("t1 held after release", int'(held[1]), 0);
        idle(10);

        // Pure bounce: no pulse
        for (int j = 0; j < 15; j++) begin
            btn_n[0] = (j % 2 == 1);
            idle(2);
        end
        btn_n[0] = 1'b1;
        idle(10);
        check("t2 held", int'(held[0]), 0);

        // Bounce then settle: one pulse, no repeat within a short hold
        for (int j = 0; j < 6; j++) begin
            btn_n[2] = (j % 2 == 1);
            idle(pat[j]);
        end
        c = cyc;
        btn_n[2] = 1'b0;
        exp_q[2].push_back(c + 7);
        idle(10);
        check("t3 held while low", int'(held[2]), 1);
        btn_n[2] = 1'b1;
        idle(12);
        check("t3 held after release", int'(held[2]), 0);

        // inc0/dec0 conflict, inc1 independent
        c = cyc;
        btn_n[0] = 1'b0;
        btn_n[2] = 1'b0;
        cfl_q.push_back(c + 7);
        @(negedge clkin);
        btn_n[1] = 1'b0;
        exp_q[1].push_back(c + 8);
        wait_to(c + 9);
        check("t4 held ch0", int'(held[0]), 1);
        check("t4 held ch2", int'(held[2]), 1);
        wait_to(c + 12);
        btn_n = '1;
        idle(12);
        check("t4 held after release", int'(held), 0);

        // Reset mid-debounce with another channel already held
        c0 = cyc;
        btn_n[0] = 1'b0;
        exp_q[0].push_back(c0 + 7);
        wait_to(c0 + 9);
        check("t5 held ch0 before reset", int'(held[0]), 1);
        c = cyc;
        btn_n[3] = 1'b0;
        wait_to(c + 3);
        #1 reset = 1'b0;
        #0.5;
        check("t5 pulse_n in reset", int'(pulse_n), 15);
        check("t5 held in reset", int'(held), 0);
        check("t5 conflict in reset", int'(conflict), 0);
        #0.5 reset = 1'b1;
        exp_q[0].push_back(c + 10);
        exp_q[3].push_back(c + 10);
        wait_to(c + 14);
        btn_n = '1;
        idle(12);
        check("t5 held after release", int'(held), 0);

        // Short release glitch while held keeps held and the repeat schedule
        c = cyc;
        btn_n[1] = 1'b0;
        exp_q[1].push_back(c + 7);
        exp_q[1].push_back(c + 27);
        wait_to(c + 15);
        btn_n[1] = 1'b1;
        idle(2);
        btn_n[1] = 1'b0;
        wait_to(c + 20);
        check("t6 held after glitch", int'(held[1]), 1);
        wait_to(c + 28);
        btn_n[1] = 1'b1;
        idle(12);
        check("t6 held after release", int'(held[1]), 0);

        idle(5);
        for (int i = 0; i < N; i++)
            check($sformatf("missing pulses ch%0d", i), exp_q[i].size(), 0);
        check("missing conflicts", cfl_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
